// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the D-stage hazard / stall controller.
// Holds the MD sequencer state type, default MD latencies and the
// single-source hazard check used for both rs and rt.
package hazard_pkg;

  // Value of tuse that means "this operand is not read".
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Default multiply/divide busy latencies and counter width.
  localparam int MUL_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT = 10;
  localparam int CNT_W_DEFAULT      = 4;

  // Number of D-stage source operands checked (rs, rt).
  localparam int NUM_SRC = 2;

  // $zero register address; it never carries a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // State of the multiply/divide busy sequencer.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // True when a D-stage source must wait for a producer in a later stage:
  // the producer writes the same non-zero register and its result arrives
  // later than the consumer needs it.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] a3,
    input logic [1:0] tnew
  );
    return (src != REG_ZERO) && (tuse != TUSE_NONE) && (tuse < tnew) && (src == a3);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_seq.sv
// Multiply/divide busy sequencer.
// A start in IDLE loads the latency of the requested operation into a
// down-counter; md_busy is high for exactly that many cycles starting the
// cycle after the start, and md_done marks the final busy cycle. Both
// outputs are registered. Starts arriving while busy are ignored.
module md_busy_seq
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic md_busy,
  output logic md_done
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  md_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             md_busy_reg;
  logic             md_done_reg;
  logic [CNT_W-1:0] load_val;

  // Latency for the operation being started this cycle.
  assign load_val = div ? DIV_LOAD : MUL_LOAD;

  // FSM with counter; busy/done are computed for the next state so they
  // leave the flops already aligned with the busy window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      md_busy_reg <= 1'b0;
      md_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= BUSY;
            cnt_reg     <= load_val;
            md_busy_reg <= 1'b1;
            // A one-cycle operation is done in its first busy cycle.
            md_done_reg <= (load_val == CNT_ONE);
          end else begin
            md_busy_reg <= 1'b0;
            md_done_reg <= 1'b0;
          end
        end
        BUSY: begin
          // Treat a zero count as final too, so a bad latency cannot wrap.
          if (cnt_reg <= CNT_ONE) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            md_busy_reg <= 1'b0;
            md_done_reg <= 1'b0;
          end else begin
            cnt_reg     <= cnt_reg - CNT_ONE;
            md_busy_reg <= 1'b1;
            md_done_reg <= (cnt_reg == CNT_TWO);
          end
        end
        default: begin
          state_reg   <= IDLE;
          cnt_reg     <= '0;
          md_busy_reg <= 1'b0;
          md_done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy = md_busy_reg;
  assign md_done = md_done_reg;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// D-stage stall controller for the 5-stage core.
// Compares D-stage source registers against the E and M destinations using
// tuse/tnew timing, adds MD-unit busy stalls, and drives PC/F-D enables and
// the D/E bubble. Stall is purely combinational from inputs and MD state.
// Optional stall-cycle statistics counter: define HAZARD_STALL_STATS_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_is_md,
  input  logic [4:0]  e_a3,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_a3,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_div,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_bubble,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  logic [4:0]         src_addr [NUM_SRC];
  logic [1:0]         src_tuse [NUM_SRC];
  logic [NUM_SRC-1:0] src_stall;
  logic               stall_md;
  logic               stall;

  // Operand table: index 0 is rs, index 1 is rt.
  assign src_addr[0] = d_rs;
  assign src_addr[1] = d_rt;
  assign src_tuse[0] = d_tuse_rs;
  assign src_tuse[1] = d_tuse_rt;

  // Per-operand data hazard against the E and M producers.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_stall[gi] = src_hazard(src_addr[gi], src_tuse[gi], e_a3, e_tnew)
                           | src_hazard(src_addr[gi], src_tuse[gi], m_a3, m_tnew);
    end
  endgenerate

  // MD instructions wait while the unit is busy or being started from E.
  assign stall_md = d_is_md & (md_busy | e_md_start);

  // Any source of stall collapses into one hold + one bubble.
  assign stall     = (|src_stall) | stall_md;
  assign pc_en     = ~stall;
  assign fd_en     = ~stall;
  assign de_bubble = stall;

  md_busy_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_busy_seq (
    .clk     (clk),
    .reset   (reset),
    .start   (e_md_start),
    .div     (e_md_div),
    .md_busy (md_busy),
    .md_done (md_done)
  );

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stall_cnt_reg;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus a
// randomized run checked against a cycle-count reference model.
module tb_hazard_stall_ctrl;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, e_a3, m_a3;
  logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic        d_is_md, e_md_start, e_md_div;
  logic        pc_en, fd_en, de_bubble, md_busy, md_done;
  logic [31:0] stall_cnt;

  int          errors = 0;
  int          checks = 0;
  int          busy_left = 0;   // model: remaining MD busy cycles
  logic [31:0] exp_cnt = '0;    // model: expected stall_cnt

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_is_md    (d_is_md),
    .e_a3       (e_a3),
    .e_tnew     (e_tnew),
    .m_a3       (m_a3),
    .m_tnew     (m_tnew),
    .e_md_start (e_md_start),
    .e_md_div   (e_md_div),
    .pc_en      (pc_en),
    .fd_en      (fd_en),
    .de_bubble  (de_bubble),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .stall_cnt  (stall_cnt)
  );

  // Reference: does one operand wait on E or M?
  function automatic bit ref_hazard(input logic [4:0] src, input logic [1:0] tuse);
    bit e_hit, m_hit;
    e_hit = (src != 0) && (src == e_a3) && (int'(tuse) < int'(e_tnew));
    m_hit = (src != 0) && (src == m_a3) && (int'(tuse) < int'(m_tnew));
    return e_hit || m_hit;
  endfunction

  function automatic bit ref_stall();
    return ref_hazard(d_rs, d_tuse_rs) || ref_hazard(d_rt, d_tuse_rt) ||
           (d_is_md && ((busy_left > 0) || e_md_start));
  endfunction

  // Advance one clock and the reference model with it.
  task automatic tick();
    bit s;
    s = ref_stall();
    @(posedge clk);
    if (reset) begin
      busy_left = 0;
      exp_cnt   = '0;
    end else begin
`ifdef HAZARD_STALL_STATS_EN
      if (s && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
`else
      s = 1'b0;
`endif
      if (busy_left > 0) busy_left = busy_left - 1;
      else if (e_md_start) busy_left = e_md_div ? DIV_N : MUL_N;
    end
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    d_rs = 0; d_rt = 0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_is_md = 0;
    e_a3 = 0; e_tnew = 0; m_a3 = 0; m_tnew = 0;
    e_md_start = 0; e_md_div = 0;
  endtask

  task automatic drain_md();
    for (int i = 0; i < 20 && busy_left > 0; i++) tick();
    settle();
    checks++;
    if (md_busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_md: md_busy=%b required 0 (timeout)", md_busy);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    settle();
    checks++;
    if ({pc_en, fd_en, de_bubble, md_busy, md_done} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_outputs: pc/fd/bub/busy/done=%b required 11000",
               {pc_en, fd_en, de_bubble, md_busy, md_done});
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    clear_inputs();
    d_rs = 5; d_tuse_rs = 0; e_a3 = 5; e_tnew = 2;
    settle();
    checks++;
    if ({pc_en, fd_en, de_bubble} !== 3'b001) begin
      errors++;
      $display("FAIL load_use_e: pc/fd/bub=%b required 001", {pc_en, fd_en, de_bubble});
    end
    tick();
    e_tnew = 0; m_a3 = 5; m_tnew = 1;
    settle();
    checks++;
    if ({pc_en, fd_en, de_bubble} !== 3'b001) begin
      errors++;
      $display("FAIL load_use_m: pc/fd/bub=%b required 001", {pc_en, fd_en, de_bubble});
    end
    tick();
    m_tnew = 0;
    settle();
    checks++;
    if ({pc_en, fd_en, de_bubble} !== 3'b110) begin
      errors++;
      $display("FAIL load_use_release: pc/fd/bub=%b required 110", {pc_en, fd_en, de_bubble});
    end
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL load_use_cnt: got %0d required %0d", stall_cnt, exp_cnt);
    end
    tick();
    $display("test_load_use done");
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    d_rs = 0; d_tuse_rs = 0; e_a3 = 0; e_tnew = 2;
    d_rt = 0; d_tuse_rt = 0; m_a3 = 0; m_tnew = 2;
    settle();
    checks++;
    if ({pc_en, de_bubble} !== 2'b10) begin
      errors++;
      $display("FAIL zero_reg: pc/bub=%b required 10", {pc_en, de_bubble});
    end
    tick();
    $display("test_zero_reg done");
  endtask

  task automatic test_multiply();
    clear_inputs();
    d_is_md = 1; e_md_start = 1; e_md_div = 0;
    settle();
    checks++;
    if ({pc_en, fd_en, de_bubble, md_busy, md_done} !== 5'b00100) begin
      errors++;
      $display("FAIL mul_start: pc/fd/bub/busy/done=%b required 00100",
               {pc_en, fd_en, de_bubble, md_busy, md_done});
    end
    tick();
    e_md_start = 0;
    for (int i = 1; i <= MUL_N; i++) begin
      settle();
      checks++;
      if ({pc_en, fd_en, de_bubble, md_busy, md_done} !== {4'b0011, i == MUL_N}) begin
        errors++;
        $display("FAIL mul_busy_%0d: pc/fd/bub/busy/done=%b required %b", i,
                 {pc_en, fd_en, de_bubble, md_busy, md_done}, {4'b0011, i == MUL_N});
      end
      tick();
    end
    settle();
    checks++;
    if ({pc_en, fd_en, de_bubble, md_busy, md_done} !== 5'b11000) begin
      errors++;
      $display("FAIL mul_end: pc/fd/bub/busy/done=%b required 11000",
               {pc_en, fd_en, de_bubble, md_busy, md_done});
    end
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL mul_cnt: got %0d required %0d", stall_cnt, exp_cnt);
    end
    $display("test_multiply done");
  endtask

  task automatic test_divide_reset();
    clear_inputs();
    d_is_md = 1; e_md_start = 1; e_md_div = 1;
    settle();
    tick();
    e_md_start = 0;
    for (int i = 1; i <= 3; i++) begin
      settle();
      checks++;
      if ({md_busy, md_done} !== 2'b10) begin
        errors++;
        $display("FAIL div_busy_%0d: busy/done=%b required 10", i, {md_busy, md_done});
      end
      if (i < 3) tick();
    end
    reset = 1;
    tick();
    reset = 0;
    settle();
    checks++;
    if ({md_busy, md_done, de_bubble, pc_en} !== 4'b0001) begin
      errors++;
      $display("FAIL div_reset: busy/done/bub/pc=%b required 0001",
               {md_busy, md_done, de_bubble, pc_en});
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL div_reset_cnt: got %0d required 0", stall_cnt);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      settle();
      checks++;
      if ({md_busy, md_done} !== 2'b00) begin
        errors++;
        $display("FAIL div_after_reset_%0d: busy/done=%b required 00", i, {md_busy, md_done});
      end
    end
    $display("test_divide_reset done");
  endtask

  task automatic test_combined();
    logic [31:0] want;
    clear_inputs();
    e_md_start = 1; e_md_div = 0;
    settle();
    tick();
    e_md_start = 0; d_is_md = 1;
    d_rt = 7; d_tuse_rt = 0; e_a3 = 7; e_tnew = 1;
    for (int k = 0; k < 2; k++) begin
      settle();
      checks++;
      if ({de_bubble, pc_en, md_busy} !== 3'b101) begin
        errors++;
        $display("FAIL combined_%0d: bub/pc/busy=%b required 101", k, {de_bubble, pc_en, md_busy});
      end
`ifdef HAZARD_STALL_STATS_EN
      want = exp_cnt + 32'd1;
`else
      want = 32'd0;
`endif
      tick();
      settle();
      checks++;
      if (stall_cnt !== want) begin
        errors++;
        $display("FAIL combined_cnt_%0d: got %0d required %0d", k, stall_cnt, want);
      end
    end
    clear_inputs();
    drain_md();
    $display("test_combined done");
  endtask

  task automatic test_non_md();
    clear_inputs();
    e_md_start = 1; e_md_div = 1;
    settle();
    tick();
    e_md_start = 0;
    d_rs = 3; d_tuse_rs = 0; e_a3 = 4; e_tnew = 2;
    settle();
    checks++;
    if ({pc_en, fd_en, de_bubble, md_busy} !== 4'b1101) begin
      errors++;
      $display("FAIL non_md: pc/fd/bub/busy=%b required 1101", {pc_en, fd_en, de_bubble, md_busy});
    end
    clear_inputs();
    drain_md();
    $display("test_non_md done");
  endtask

  task automatic test_random();
    bit s;
    logic [4:0] want;
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 49) == 0);
      d_rs       = 5'($urandom_range(0, 3));
      d_rt       = 5'($urandom_range(0, 3));
      e_a3       = 5'($urandom_range(0, 3));
      m_a3       = 5'($urandom_range(0, 3));
      d_tuse_rs  = 2'($urandom_range(0, 3));
      d_tuse_rt  = 2'($urandom_range(0, 3));
      e_tnew     = 2'($urandom_range(0, 3));
      m_tnew     = 2'($urandom_range(0, 3));
      d_is_md    = 1'($urandom_range(0, 1));
      e_md_start = ($urandom_range(0, 3) == 0);
      e_md_div   = 1'($urandom_range(0, 1));
      settle();
      s = ref_stall();
      want = {~s, ~s, s, busy_left > 0, busy_left == 1};
      checks++;
      if ({pc_en, fd_en, de_bubble, md_busy, md_done} !== want) begin
        errors++;
        $display("FAIL random_%0d: pc/fd/bub/busy/done=%b required %b", n,
                 {pc_en, fd_en, de_bubble, md_busy, md_done}, want);
      end
      checks++;
      if (stall_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL random_cnt_%0d: got %0d required %0d", n, stall_cnt, exp_cnt);
      end
      tick();
    end
    reset = 0;
    $display("test_random done");
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    #1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_multiply();
    test_divide_reset();
    test_combined();
    test_non_md();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Producer side of the pipeline-register stall interface for the 5-stage core.
- Decides each cycle whether the D-stage instruction must wait. On a wait it freezes PC and the F/D register, and injects a bubble into the D/E register by driving that register's clear-on-stall input.
- Owns the multiply/divide busy sequencer, so MD-type instructions stall while the MD unit is busy.
- Sits beside the datapath; consumes decoded register-use info from D, E and M.

Parameters:
- MUL_CYCLES, 5, busy cycles for a multiply (range 1..15).
- DIV_CYCLES, 10, busy cycles for a divide (range 1..15).
- CNT_W, 4, busy counter width; must satisfy 2^CNT_W-1 >= max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- d_rs  in  5  D-stage rs address.
- d_rt  in  5  D-stage rt address.
- d_tuse_rs  in  2  cycles until rs is needed (3 = not used).
- d_tuse_rt  in  2  cycles until rt is needed (3 = not used).
- d_is_md  in  1  D instruction reads or writes HI/LO or starts the MD unit.
- e_a3  in  5  E-stage destination register.
- e_tnew  in  2  cycles until the E result is available.
- m_a3  in  5  M-stage destination register.
- m_tnew  in  2  cycles until the M result is available.
- e_md_start  in  1  E instruction starts the MD unit this cycle.
- e_md_div  in  1  1 = divide, 0 = multiply; qualified by e_md_start.
- pc_en  out  1  PC write enable.
- fd_en  out  1  F/D register enable.
- de_bubble  out  1  drives the isStall input of the D/E register (1 = load zeros).
- md_busy  out  1  MD unit busy.
- md_done  out  1  one-cycle pulse on the last busy cycle.
- stall_cnt  out  32  stall-cycle count (see Optional Feature).

Behaviour:
- Data stall: `stall_rs = (d_rs != 0) & (d_tuse_rs < e_tnew) & (d_rs == e_a3) | (d_rs != 0) & (d_tuse_rs < m_tnew) & (d_rs == m_a3)`. `stall_rt` is the same with rt. `e_a3`/`m_a3 == 0` never matches, via the `!= 0` term.
- MD stall: `stall_md = d_is_md & (md_busy | e_md_start)`.
- `stall = stall_rs | stall_rt | stall_md`. It is combinational from the inputs and the registered state; there is no registered latency on stall.
- Outputs: `pc_en = ~stall`, `fd_en = ~stall`, `de_bubble = stall`. While stalling, the D instruction is held and a nop enters E; stalls may last any number of consecutive cycles.
- MD FSM, states IDLE and BUSY, with down-counter `cnt[CNT_W-1:0]`:
  - IDLE: if `e_md_start`, load `cnt = (e_md_div ? DIV_CYCLES : MUL_CYCLES)` and go to BUSY.
  - BUSY: decrement `cnt` each cycle. When `cnt == 1`, assert `md_done` and return to IDLE next cycle.
  - `md_busy = (state == BUSY)`. It rises the cycle after the start and stays high for exactly N cycles.
  - `e_md_start` while in BUSY is ignored; it cannot occur legally, because `stall_md` blocks it.
- Reset: state = IDLE, `cnt = 0`, `md_done = 0`, `md_busy = 0`, `stall_cnt = 0`. The combinational outputs follow from this state. Reset in mid-operation aborts the MD operation immediately.
- Simultaneous data stall and MD stall: a single stall, counted once.

Optional Feature:
- Macro `HAZARD_STALL_STATS_EN`.
- When defined: `stall_cnt` increments on every cycle where stall = 1 and reset = 0, and saturates at 32'hFFFF_FFFF.
- When undefined: `stall_cnt` is tied to 0 and no counter flops are generated.

Decomposition:
- Shared package `hazard_pkg`:
  - `TUSE_NONE = 2'd3`.
  - `md_state_t` enum {IDLE, BUSY}.
  - Default `MUL_CYCLES` / `DIV_CYCLES` constants.
- One natural sub-module, `md_busy_seq`: the FSM and counter, with outputs `md_busy` and `md_done`. Comparison logic stays in the top module.

Test Plan:
- Load-use: `d_rs = 5`, `d_tuse_rs = 0`, `e_a3 = 5`, `e_tnew = 2` -> `pc_en = 0`, `fd_en = 0`, `de_bubble = 1`. Then `e_tnew = 0`, `m_a3 = 5`, `m_tnew = 1` -> still stalled. Then `m_tnew = 0` -> released.
- $zero: `d_rs = 0`, `e_a3 = 0`, `e_tnew = 2`, `d_tuse_rs = 0` -> no stall.
- Multiply: `e_md_start = 1`, `e_md_div = 0` -> `md_busy` high for exactly 5 cycles and `md_done` on the 5th. With `d_is_md = 1` throughout, stall is 1 in the start cycle plus the 5 busy cycles.
- Divide mid-reset: start a divide, assert reset at busy cycle 3 -> next cycle `md_busy = 0`, no `md_done`, stall = 0.
- Combined: rt hazard plus MD busy in the same cycle -> `de_bubble = 1`. `stall_cnt` increments by 1 per cycle when `HAZARD_STALL_STATS_EN` is defined, and stays 0 when undefined.
- Non-MD D instruction during busy (`d_is_md = 0`, no data hazard) -> no stall, `pc_en = 1`.
